// File: rtl/serial_chunk_subtractor.sv
// Multi-cycle subtractor: result = A - B - borrow_i, one CHUNK_WIDTH slice per clock, LSB first.
// Optional macro SUB_OVERFLOW_EN adds a registered two's-complement overflow flag (overflow_o).
module serial_chunk_subtractor #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] operand_A_i,
  input  logic [DATA_WIDTH-1:0] operand_B_i,
  input  logic                  borrow_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  borrow_o,
  output logic                  valid_o,
  output logic                  idle_o
`ifdef SUB_OVERFLOW_EN
  ,
  output logic                  overflow_o
`endif
);

  localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    SUBTRACT = 1'b1
  } state_e;

  state_e                  state_r;
  logic [DATA_WIDTH-1:0]   a_r;
  logic [DATA_WIDTH-1:0]   b_r;
  logic [DATA_WIDTH-1:0]   work_r;
  logic                    borrow_r;
  logic [CNT_W-1:0]        cnt_r;
`ifdef SUB_OVERFLOW_EN
  logic                    a_msb_r;
  logic                    b_msb_r;
`endif

  logic [CHUNK_WIDTH:0]    sum_s;
  logic                    carry_s;
  logic [CHUNK_WIDTH-1:0]  diff_s;
  logic [DATA_WIDTH-1:0]   work_next_s;
  logic                    last_chunk_s;

  // Subtraction as A + ~B + ~borrow; the carry out is the inverted borrow.
  assign sum_s = {1'b0, a_r[CHUNK_WIDTH-1:0]}
               + {1'b0, ~b_r[CHUNK_WIDTH-1:0]}
               + {{CHUNK_WIDTH{1'b0}}, ~borrow_r};
  assign carry_s      = sum_s[CHUNK_WIDTH];
  assign diff_s       = sum_s[CHUNK_WIDTH-1:0];
  assign work_next_s  = (work_r >> CHUNK_WIDTH)
                      | (DATA_WIDTH'(diff_s) << (DATA_WIDTH - CHUNK_WIDTH));
  assign last_chunk_s = (cnt_r == CNT_W'(N - 1));

  // Control FSM, operand/working datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= IDLE;
      a_r        <= {DATA_WIDTH{1'b0}};
      b_r        <= {DATA_WIDTH{1'b0}};
      work_r     <= {DATA_WIDTH{1'b0}};
      borrow_r   <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      result_o   <= {DATA_WIDTH{1'b0}};
      borrow_o   <= 1'b0;
      valid_o    <= 1'b0;
      idle_o     <= 1'b1;
`ifdef SUB_OVERFLOW_EN
      a_msb_r    <= 1'b0;
      b_msb_r    <= 1'b0;
      overflow_o <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid_i) begin
            a_r      <= operand_A_i;
            b_r      <= operand_B_i;
            borrow_r <= borrow_i;
            cnt_r    <= {CNT_W{1'b0}};
            state_r  <= SUBTRACT;
            idle_o   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb_r  <= operand_A_i[DATA_WIDTH-1];
            b_msb_r  <= operand_B_i[DATA_WIDTH-1];
`endif
          end else begin
            state_r <= IDLE;
            idle_o  <= 1'b1;
          end
        end
        SUBTRACT: begin
          borrow_r <= ~carry_s;
          work_r   <= work_next_s;
          a_r      <= a_r >> CHUNK_WIDTH;
          b_r      <= b_r >> CHUNK_WIDTH;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (last_chunk_s) begin
            result_o   <= work_next_s;
            borrow_o   <= ~carry_s;
            valid_o    <= 1'b1;
            state_r    <= IDLE;
            idle_o     <= 1'b1;
`ifdef SUB_OVERFLOW_EN
            overflow_o <= (a_msb_r != b_msb_r) && (work_next_s[DATA_WIDTH-1] != a_msb_r);
`endif
          end else begin
            state_r <= SUBTRACT;
            idle_o  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          idle_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_chunk_subtractor.sv
// Scoreboard bench for serial_chunk_subtractor (32-bit data, 8-bit chunks, 4-cycle latency).
// Builds with or without SUB_OVERFLOW_EN; the overflow flag is checked only when present.
module tb_serial_chunk_subtractor;

  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int LAT = DW / CW;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          valid_i;
  logic [DW-1:0] operand_A_i;
  logic [DW-1:0] operand_B_i;
  logic          borrow_i;
  logic [DW-1:0] result_o;
  logic          borrow_o;
  logic          valid_o;
  logic          idle_o;
`ifdef SUB_OVERFLOW_EN
  logic          overflow_o;
`endif

  serial_chunk_subtractor #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .valid_i     (valid_i),
    .operand_A_i (operand_A_i),
    .operand_B_i (operand_B_i),
    .borrow_i    (borrow_i),
    .result_o    (result_o),
    .borrow_o    (borrow_o),
    .valid_o     (valid_o),
    .idle_o      (idle_o)
`ifdef SUB_OVERFLOW_EN
    ,
    .overflow_o  (overflow_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] res;
    logic          bo;
    logic          ovf;
    int            cap;
  } exp_t;

  exp_t          sb_q[$];
  int            n_vec    = 0;
  int            n_miscmp = 0;
  int            cyc      = 0;
  logic [DW-1:0] last_res;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bi);
    exp_t      e;
    logic [DW:0] full;
    full  = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, bi};
    e.res = full[DW-1:0];
    e.bo  = full[DW];
    e.ovf = (a[DW-1] != b[DW-1]) && (full[DW-1] != a[DW-1]);
    e.cap = 0;
    return e;
  endfunction

  // Monitor: pops expectations on valid_o, and checks held outputs while busy.
  initial begin
    exp_t e;
    last_res = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        last_res = '0;
      end else if (valid_o) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_valid", 64'(valid_o), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("result", 64'(result_o), 64'(e.res));
          check_val("borrow", 64'(borrow_o), 64'(e.bo));
          check_val("latency", 64'(cyc - e.cap), 64'(LAT));
`ifdef SUB_OVERFLOW_EN
          check_val("overflow", 64'(overflow_o), 64'(e.ovf));
`endif
          last_res = e.res;
        end
      end else if (sb_q.size() != 0) begin
        check_val("idle_busy", 64'(idle_o), 64'd0);
        check_val("result_hold", 64'(result_o), 64'(last_res));
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (!idle_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    if (!idle_o) check_val("idle_timeout", 64'(idle_o), 64'd1);
  endtask

  // Drives one start pulse at a negedge; pushes the expectation after the capture edge.
  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bi);
    exp_t e;
    wait_idle();
    operand_A_i = a;
    operand_B_i = b;
    borrow_i    = bi;
    valid_i     = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    e     = model(a, b, bi);
    e.cap = cyc;
    sb_q.push_back(e);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    if (sb_q.size() != 0) check_val("drain_timeout", 64'(sb_q.size()), 64'd0);
    @(negedge clk_i);
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bi);
    start_op(a, b, bi);
    drain();
  endtask

  initial begin
    exp_t e;
    rst_n_i     = 1'b0;
    valid_i     = 1'b0;
    operand_A_i = '0;
    operand_B_i = '0;
    borrow_i    = 1'b0;
    #12;
    check_val("rst_idle", 64'(idle_o), 64'd1);
    check_val("rst_valid", 64'(valid_o), 64'd0);
    check_val("rst_result", 64'(result_o), 64'd0);
    check_val("rst_borrow", 64'(borrow_o), 64'd0);
`ifdef SUB_OVERFLOW_EN
    check_val("rst_overflow", 64'(overflow_o), 64'd0);
`endif
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    run_op(32'h0000_0005, 32'h0000_0003, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op(32'h0000_0100, 32'h0000_0001, 1'b0);
    run_op(32'h0000_0010, 32'h0000_0010, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);

    // valid_i held with junk during SUBTRACT, then a real op in the valid_o cycle.
    start_op(32'h1234_5678, 32'h0123_4567, 1'b0);
    valid_i     = 1'b1;
    operand_A_i = 32'hDEAD_BEEF;
    operand_B_i = 32'h0BAD_F00D;
    borrow_i    = 1'b1;
    repeat (LAT) @(negedge clk_i);
    check_val("b2b_valid_cycle", 64'(valid_o), 64'd1);
    operand_A_i = 32'hA5A5_0000;
    operand_B_i = 32'h0000_5A5A;
    borrow_i    = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    e     = model(32'hA5A5_0000, 32'h0000_5A5A, 1'b1);
    e.cap = cyc;
    sb_q.push_back(e);
    valid_i = 1'b0;
    drain();

    // Reset in the second cycle of an operation aborts it.
    start_op(32'h0000_0100, 32'h0000_0001, 1'b0);
    rst_n_i = 1'b0;
    sb_q.delete();
    #1;
    check_val("abort_idle", 64'(idle_o), 64'd1);
    check_val("abort_valid", 64'(valid_o), 64'd0);
    check_val("abort_result", 64'(result_o), 64'd0);
    check_val("abort_borrow", 64'(borrow_o), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk_i);
      check_val("abort_no_valid", 64'(valid_o), 64'd0);
    end
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_op($urandom(), $urandom(), 1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
